// File: rtl/seven_seg_time_checker.sv
// Display-side monitor for a HH:MM:SS seven-segment clock. It decodes the six segment buses back
// to BCD, checks that every change is exactly +1 s (23:59:59 -> 00:00:00), and counts errors.
module seven_seg_time_checker #(
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 1023
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       sec0,
    input  logic [7:0]       sec1,
    input  logic [7:0]       min0,
    input  logic [7:0]       min1,
    input  logic [7:0]       hour0,
    input  logic [7:0]       hour1,
    input  logic             clr_err,
    output logic [23:0]      bcd_time,
    output logic             time_valid,
    output logic             tick,
    output logic             err_pattern,
    output logic             err_step,
    output logic             err_stall,
    output logic [CNT_W-1:0] err_count
);

    localparam int                 STALL_W   = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam bit                 STALL_EN  = (STALL_LIMIT > 0);

    typedef enum logic {SYNC, TRACK} state_t;

    state_t             state, state_next;
    logic [5:0][6:0]    s1_seg;
    logic               s1_vld;
    logic [5:0][4:0]    dec;
    logic [23:0]        sample;
    logic               all_ok, in_range, legal;
    logic [23:0]        time_next;
    logic [STALL_W-1:0] stall_cnt, stall_next;
    logic               tick_next, ev_pattern, ev_step, ev_stall, ev_any;
    logic [CNT_W-1:0]   count_next;
    logic               unused_dp;

    assign unused_dp = ^{sec0[7], sec1[7], min0[7], min1[7], hour0[7], hour1[7]};

    // Returns {ok, digit}; the decimal point is dropped before this point.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'd0};
            7'h06:   return {1'b1, 4'd1};
            7'h5B:   return {1'b1, 4'd2};
            7'h4F:   return {1'b1, 4'd3};
            7'h66:   return {1'b1, 4'd4};
            7'h6D:   return {1'b1, 4'd5};
            7'h7D:   return {1'b1, 4'd6};
            7'h07:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h6F:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [23:0] inc_time(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) r[7:4] = t[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
                else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
                    else begin
                        r[15:12] = 4'd0;
                        if (t[23:16] == 8'h23)       r[23:16] = 8'h00;
                        else if (t[19:16] != 4'd9)   r[19:16] = t[19:16] + 4'd1;
                        else begin
                            r[19:16] = 4'd0;
                            r[23:20] = t[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // s1_vld masks the reset contents of s1_seg so the first cycle out of reset is not an error.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_seg <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_seg <= {hour1[6:0], hour0[6:0], min1[6:0], min0[6:0], sec1[6:0], sec0[6:0]};
            s1_vld <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec    = '0;
        sample = '0;
        all_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dec[i]           = decode(s1_seg[i]);
            all_ok           = all_ok & dec[i][4];
            sample[4*i +: 4] = dec[i][3:0];
        end
        in_range = (sample[7:4] <= 4'd5) && (sample[15:12] <= 4'd5) &&
                   ((sample[23:20] < 4'd2) || ((sample[23:20] == 4'd2) && (sample[19:16] <= 4'd3)));
        legal    = s1_vld & all_ok & in_range;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= SYNC;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == SYNC && legal) state_next = TRACK;
    end

    // Every legal sample becomes the new reference: load, equal, +1 s and resync all agree on that.
    always_comb begin
        ev_pattern = s1_vld & ~legal;
        ev_step    = 1'b0;
        ev_stall   = 1'b0;
        tick_next  = 1'b0;
        time_next  = legal ? sample : bcd_time;
        stall_next = stall_cnt;
        if (state == TRACK && legal) begin
            if (sample == bcd_time) begin
                if (STALL_EN && stall_cnt != STALL_MAX) begin
                    stall_next = stall_cnt + STALL_W'(1);
                    ev_stall   = (stall_next == STALL_MAX);
                end
            end else begin
                stall_next = '0;
                tick_next  = (sample == inc_time(bcd_time));
                ev_step    = ~tick_next;
            end
        end
        ev_any     = ev_pattern | ev_step | ev_stall;
        count_next = err_count;
        if (clr_err)                      count_next = ev_any ? CNT_W'(1) : '0;
        else if (ev_any && ~&err_count)   count_next = err_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bcd_time    <= '0;
            time_valid  <= 1'b0;
            tick        <= 1'b0;
            err_pattern <= 1'b0;
            err_step    <= 1'b0;
            err_stall   <= 1'b0;
            err_count   <= '0;
            stall_cnt   <= '0;
        end else begin
            bcd_time    <= time_next;
            time_valid  <= legal;
            tick        <= tick_next;
            err_pattern <= ev_pattern | (err_pattern & ~clr_err);
            err_step    <= ev_step    | (err_step    & ~clr_err);
            err_stall   <= ev_stall   | (err_stall   & ~clr_err);
            err_count   <= count_next;
            stall_cnt   <= stall_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_time_checker.sv
// Bench for seven_seg_time_checker: directed scenarios plus a random walk, all checked
// cycle by cycle against a seconds-of-day reference model.
module tb_seven_seg_time_checker;

    localparam int LIM     = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    localparam int DAY     = 86400;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [7:0]       pat [6];
    logic             clr_err = 1'b0;
    logic [23:0]      bcd_time;
    logic             time_valid, tick, err_pattern, err_step, err_stall;
    logic [CNT_W-1:0] err_count;

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    int n_checks = 0;
    int n_fail   = 0;
    int tick_seen = 0;

    // reference model state: time is kept as seconds since midnight
    bit         m_s1_vld;
    logic [7:0] m_s1 [6];
    bit         m_tracking;
    int         m_ref, m_stall, m_cnt;
    bit         m_valid, m_tick, m_ep, m_es, m_est;

    seven_seg_time_checker #(.CNT_W(CNT_W), .STALL_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .sec0(pat[0]), .sec1(pat[1]), .min0(pat[2]), .min1(pat[3]), .hour0(pat[4]), .hour1(pat[5]),
        .clr_err(clr_err),
        .bcd_time(bcd_time), .time_valid(time_valid), .tick(tick),
        .err_pattern(err_pattern), .err_step(err_step), .err_stall(err_stall),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int seg_digit(input logic [7:0] p);
        for (int i = 0; i < 10; i++)
            if (p[6:0] == seg_tab[i][6:0]) return i;
        return -1;
    endfunction

    // Decode the captured sample to seconds of day; returns 0 if it is not a legal time.
    function automatic bit sample_secs(output int t);
        int d [6];
        t = 0;
        for (int i = 0; i < 6; i++) begin
            d[i] = seg_digit(m_s1[i]);
            if (d[i] < 0) return 1'b0;
        end
        if (d[1] > 5 || d[3] > 5 || d[5] > 2 || (d[5] * 10 + d[4]) > 23) return 1'b0;
        t = (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_s1_vld = 0; m_tracking = 0; m_ref = 0; m_stall = 0; m_cnt = 0;
        m_valid = 0; m_tick = 0; m_ep = 0; m_es = 0; m_est = 0;
        for (int i = 0; i < 6; i++) m_s1[i] = 8'h00;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_clock();
        int t;
        bit ev_p, ev_s, ev_st;
        ev_p = 0; ev_s = 0; ev_st = 0;
        m_tick = 0;
        m_valid = 0;
        if (m_s1_vld) begin
            if (!sample_secs(t)) begin
                ev_p = 1;
            end else begin
                m_valid = 1;
                if (!m_tracking) begin
                    m_ref = t; m_tracking = 1; m_stall = 0;
                end else if (t == m_ref) begin
                    if (m_stall < LIM) begin
                        m_stall++;
                        if (m_stall == LIM) ev_st = 1;
                    end
                end else if (t == (m_ref + 1) % DAY) begin
                    m_tick = 1; m_ref = t; m_stall = 0;
                end else begin
                    ev_s = 1; m_ref = t; m_stall = 0;
                end
            end
        end
        if (clr_err) begin
            m_ep = ev_p; m_es = ev_s; m_est = ev_st;
            m_cnt = (ev_p | ev_s | ev_st) ? 1 : 0;
        end else begin
            m_ep |= ev_p; m_es |= ev_s; m_est |= ev_st;
            if ((ev_p | ev_s | ev_st) && m_cnt < CNT_MAX) m_cnt++;
        end
        for (int i = 0; i < 6; i++) m_s1[i] = pat[i];
        m_s1_vld = 1;
    endtask

    task automatic compare_all();
        check("bcd_time",    bcd_time,    to_bcd(m_ref));
        check("time_valid",  time_valid,  m_valid);
        check("tick",        tick,        m_tick);
        check("err_pattern", err_pattern, m_ep);
        check("err_step",    err_step,    m_es);
        check("err_stall",   err_stall,   m_est);
        check("err_count",   err_count,   m_cnt);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_clock();
            @(posedge clk);
            #1;
            compare_all();
            if (tick) tick_seen++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        resetn = 1'b1;
        tick_seen = 0;
    endtask

    task automatic set_time(input int t, input bit rnd_dp);
        int v [6];
        v[0] = t % 10;          v[1] = (t / 10) % 6;
        v[2] = (t / 60) % 10;   v[3] = (t / 600) % 6;
        v[4] = (t / 3600) % 10; v[5] = t / 36000;
        for (int i = 0; i < 6; i++)
            pat[i] = {rnd_dp ? 1'($urandom) : 1'b0, seg_tab[v[i]][6:0]};
    endtask

    initial begin
        int t;
        int unsigned r;
        for (int i = 0; i < 6; i++) pat[i] = 8'h3F;
        model_reset();

        // 1: count 00:00:00 up to 00:01:05, one step every 4 clocks
        do_reset();
        check("reset_bcd", bcd_time, 32'h0);
        check("reset_valid", time_valid, 1'b0);
        for (int s = 0; s <= 65; s++) begin
            set_time(s, 1'b0);
            step(4);
        end
        check("s1_ticks", tick_seen, 65);
        check("s1_bcd", bcd_time, 32'h000105);
        check("s1_count", err_count, 0);
        check("s1_flags", {err_pattern, err_step, err_stall}, 3'b000);

        // 2: midnight wrap
        do_reset();
        set_time(DAY - 2, 1'b0); step(4);
        set_time(DAY - 1, 1'b0); step(4);
        set_time(0, 1'b0);       step(4);
        check("s2_ticks", tick_seen, 2);
        check("s2_bcd", bcd_time, 32'h0);
        check("s2_step", err_step, 1'b0);

        // 3: jump 12:00:00 -> 12:00:05, then +1 s from the new value; also checks latency 2
        do_reset();
        set_time(43200, 1'b0); step(4);
        set_time(43205, 1'b0); step(1);
        check("s3_latency", err_step, 1'b0);
        step(1);
        check("s3_step", err_step, 1'b1);
        check("s3_count", err_count, 1);
        check("s3_notick", tick_seen, 0);
        step(2);
        set_time(43206, 1'b0); step(4);
        check("s3_tick", tick_seen, 1);
        check("s3_bcd", bcd_time, 32'h120006);

        // 4: one illegal sec0 pattern, then +1 s from the old reference
        do_reset();
        set_time(43200, 1'b0); step(4);
        pat[0] = 8'h00;        step(2);
        check("s4_pattern", err_pattern, 1'b1);
        check("s4_valid", time_valid, 1'b0);
        check("s4_keep", bcd_time, 32'h120000);
        step(2);
        set_time(43201, 1'b0); step(4);
        check("s4_tick", tick_seen, 1);
        check("s4_step", err_step, 1'b0);
        check("s4_valid2", time_valid, 1'b1);

        // 5: stall on 01:02:03, no retrigger, then clear
        do_reset();
        set_time(3723, 1'b0); step(9);
        check("s5_early", err_stall, 1'b0);
        step(1);
        check("s5_stall", err_stall, 1'b1);
        check("s5_count", err_count, 1);
        step(2);
        check("s5_hold", err_count, 1);
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        check("s5_clr", {err_pattern, err_step, err_stall, 4'(err_count)}, 7'd0);
        set_time(3724, 1'b0); step(4);
        check("s5_tick", tick_seen, 1);

        // 6: hour 24 is illegal; reset mid-stream, then a fresh SYNC load
        do_reset();
        for (int i = 0; i < 4; i++) pat[i] = 8'h3F;
        pat[4] = 8'h66; pat[5] = 8'h5B;
        step(2);
        check("s6_pattern", err_pattern, 1'b1);
        do_reset();
        check("s6_rst_pat", err_pattern, 1'b0);
        check("s6_rst_cnt", err_count, 0);
        set_time(5 * 3600, 1'b0); step(4);
        check("s6_valid", time_valid, 1'b1);
        check("s6_nostep", err_step, 1'b0);
        check("s6_bcd", bcd_time, 32'h050000);

        // saturation, then clear in a cycle that also has an error
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_time(i * 7, 1'b0);
            step(1);
        end
        step(2);
        check("sat_count", err_count, CNT_MAX);
        set_time(500, 1'b0); step(1);
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        check("clr_win_cnt", err_count, 1);
        check("clr_win_flag", err_step, 1'b1);

        // random walk: holds, +1 s, jumps, corrupted digits, clears, random dp bits
        do_reset();
        t = $urandom_range(0, DAY - 1);
        set_time(t, 1'b1);
        for (int c = 0; c < 2500; c++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                set_time(t, 1'b1);
            end else if (r < 85) begin
                t = (t + 1) % DAY;
                set_time(t, 1'b1);
            end else if (r < 90) begin
                t = $urandom_range(0, DAY - 1);
                set_time(t, 1'b1);
            end else if (r < 95) begin
                pat[$urandom_range(0, 5)] = 8'($urandom);
            end
            clr_err = (r >= 97);
            step(1);
        end
        clr_err = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
